// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle R-type controller:
// state encodings, supported funct codes and ALUCtl codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_t;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_NOR = 6'd39;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/sequencer bundle.
// master: controller side (takes run/step/clr_trap/imem_ready/funct,
//         drives strobes, alu_ctl, state and status).
// slave:  the opposite side.
interface mips_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic             clr_trap;
  logic             imem_ready;
  logic [5:0]       funct;
  logic             pc_write;
  logic             ir_write;
  logic             ab_load;
  logic             alu_out_load;
  logic             reg_write;
  logic [3:0]       alu_ctl;
  logic [2:0]       state;
  logic             busy;
  logic             retire;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  run, step, clr_trap, imem_ready, funct,
    output pc_write, ir_write, ab_load, alu_out_load, reg_write,
           alu_ctl, state, busy, retire, illegal, timeout, retire_count
  );

  modport slave (
    output run, step, clr_trap, imem_ready, funct,
    input  pc_write, ir_write, ab_load, alu_out_load, reg_write,
           alu_ctl, state, busy, retire, illegal, timeout, retire_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl_funct_decode.sv
// R-type funct -> ALUCtl mapping. Unsupported funct gives ALU_BAD, legal=0.
module mips_funct_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       legal
);

  always_comb begin
    alu_ctl = ALU_BAD;
    legal   = 1'b1;
    case (funct)
      FUNCT_ADD: alu_ctl = ALU_ADD;
      FUNCT_SUB: alu_ctl = ALU_SUB;
      FUNCT_AND: alu_ctl = ALU_AND;
      FUNCT_OR:  alu_ctl = ALU_OR;
      FUNCT_NOR: alu_ctl = ALU_NOR;
      FUNCT_SLT: alu_ctl = ALU_SLT;
      default:   legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle R-type control FSM: FETCH/DECODE/EXECUTE/WRITEBACK with
// run/step execution, fetch wait timeout and illegal-funct trap.
// Ports: CLK, RESET (async, active-high), bus (controller modport).
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  mips_multicycle_ctrl_if.master       bus
);

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t           state_q;
  logic [7:0]       wait_cnt;
  logic             single_mode;
  logic [3:0]       alu_ctl_q;
  logic             ab_load_q, alu_out_load_q, reg_write_q, retire_q;
  logic             busy_q, illegal_q, timeout_q;
  logic [CNT_W-1:0] retire_cnt;
  logic [3:0]       dec_ctl;
  logic             dec_legal;

  mips_funct_decode u_decode (
    .funct   (bus.funct),
    .alu_ctl (dec_ctl),
    .legal   (dec_legal)
  );

  // Phase strobes other than the fetch pair are set on the edge entering
  // their phase, so they behave as Moore outputs while being registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      wait_cnt       <= '0;
      single_mode    <= 1'b0;
      alu_ctl_q      <= ALU_BAD;
      ab_load_q      <= 1'b0;
      alu_out_load_q <= 1'b0;
      reg_write_q    <= 1'b0;
      retire_q       <= 1'b0;
      busy_q         <= 1'b0;
      illegal_q      <= 1'b0;
      timeout_q      <= 1'b0;
      retire_cnt     <= '0;
    end else begin
      ab_load_q      <= 1'b0;
      alu_out_load_q <= 1'b0;
      reg_write_q    <= 1'b0;
      retire_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.run || bus.step) begin
            state_q     <= ST_FETCH;
            single_mode <= ~bus.run;
            busy_q      <= 1'b1;
            wait_cnt    <= '0;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state_q   <= ST_DECODE;
            ab_load_q <= 1'b1;
            wait_cnt  <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q   <= ST_TRAP;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          alu_ctl_q <= dec_ctl;
          if (dec_legal) begin
            state_q        <= ST_EXECUTE;
            alu_out_load_q <= 1'b1;
          end else begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        ST_EXECUTE: begin
          state_q     <= ST_WRITEBACK;
          reg_write_q <= 1'b1;
          retire_q    <= 1'b1;
        end
        ST_WRITEBACK: begin
          retire_cnt <= retire_cnt + 1'b1;
          if (bus.run && !single_mode) begin
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_TRAP: begin
          if (bus.clr_trap) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_write     = (state_q == ST_FETCH) && bus.imem_ready;
  assign bus.ir_write     = (state_q == ST_FETCH) && bus.imem_ready;
  assign bus.ab_load      = ab_load_q;
  assign bus.alu_out_load = alu_out_load_q;
  assign bus.reg_write    = reg_write_q;
  assign bus.alu_ctl      = alu_ctl_q;
  assign bus.state        = state_q;
  assign bus.busy         = busy_q;
  assign bus.retire       = retire_q;
  assign bus.illegal      = illegal_q;
  assign bus.timeout      = timeout_q;
  assign bus.retire_count = retire_cnt;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table,
// hand-written corner sequences, randomized run checked against a
// phase-level reference model, and counter wrap on a narrow instance.
module tb_mips_multicycle_ctrl;

  localparam int unsigned TO = 8;

  logic CLK = 1'b0;
  logic RESET;
  logic rst2;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl_if #(.CNT_W(16)) bus ();
  mips_multicycle_ctrl_if #(.CNT_W(4))  bus2 ();

  mips_multicycle_ctrl #(.FETCH_TIMEOUT(TO), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  mips_multicycle_ctrl #(.FETCH_TIMEOUT(TO), .CNT_W(4)) dut2 (
    .CLK   (CLK),
    .RESET (rst2),
    .bus   (bus2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model: mode 0 idle, 1 running, 2 trapped; phase 0..3 within
  // an instruction (fetch, decode, execute, writeback)
  int          m_mode;
  int          m_phase;
  int          m_wait;
  bit          m_single;
  logic [3:0]  m_alu;
  bit          m_ill;
  bit          m_to;
  int unsigned m_cnt;

  typedef struct {
    logic       run;
    logic       ready;
    logic [5:0] funct;
    logic [2:0] st;
    logic [4:0] strb;
    logic [3:0] alu;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'd32:   return 4'd2;
      6'd34:   return 4'd6;
      6'd36:   return 4'd0;
      6'd37:   return 4'd1;
      6'd39:   return 4'd12;
      6'd42:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_wait = 0; m_single = 0;
    m_alu = 4'hF; m_ill = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (RESET) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (bus.run || bus.step) begin
        m_mode = 1; m_phase = 0; m_wait = 0; m_single = !bus.run;
      end
      1: case (m_phase)
        0: if (bus.imem_ready) m_phase = 1;
           else begin
             m_wait++;
             if (m_wait >= TO) begin m_mode = 2; m_to = 1; end
           end
        1: begin
          m_alu = ref_alu(bus.funct);
          if (m_alu == 4'd15) begin m_mode = 2; m_ill = 1; end
          else m_phase = 2;
        end
        2: m_phase = 3;
        default: begin
          m_cnt = (m_cnt + 1) & 32'hFFFF;
          if (bus.run && !m_single) begin m_phase = 0; m_wait = 0; end
          else m_mode = 0;
        end
      endcase
      default: if (bus.clr_trap) begin m_mode = 0; m_ill = 0; m_to = 0; end
    endcase
  endtask

  task automatic check_model();
    bit run_ph;
    logic [2:0] st;
    run_ph = (m_mode == 1);
    st = (m_mode == 0) ? 3'd0 : (m_mode == 2) ? 3'd5 : 3'(m_phase + 1);
    chk("state",        32'(bus.state),        32'(st));
    chk("pc_write",     32'(bus.pc_write),     32'(run_ph && m_phase == 0 && bus.imem_ready));
    chk("ir_write",     32'(bus.ir_write),     32'(run_ph && m_phase == 0 && bus.imem_ready));
    chk("ab_load",      32'(bus.ab_load),      32'(run_ph && m_phase == 1));
    chk("alu_out_load", 32'(bus.alu_out_load), 32'(run_ph && m_phase == 2));
    chk("reg_write",    32'(bus.reg_write),    32'(run_ph && m_phase == 3));
    chk("retire",       32'(bus.retire),       32'(run_ph && m_phase == 3));
    chk("busy",         32'(bus.busy),         32'(run_ph));
    chk("alu_ctl",      32'(bus.alu_ctl),      32'(m_alu));
    chk("illegal",      32'(bus.illegal),      32'(m_ill));
    chk("timeout",      32'(bus.timeout),      32'(m_to));
    chk("retire_count", 32'(bus.retire_count), m_cnt);
  endtask

  task automatic advance();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check_model();
      advance();
    end
  endtask

  task automatic set_in(input logic r, input logic s, input logic c, input logic rdy, input logic [5:0] f);
    bus.run = r; bus.step = s; bus.clr_trap = c; bus.imem_ready = rdy; bus.funct = f;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 6'd32, 3'd0, 5'b00000, 4'hF};
    vecs[1] = '{1'b1, 1'b1, 6'd32, 3'd1, 5'b11000, 4'hF};
    vecs[2] = '{1'b1, 1'b1, 6'd32, 3'd2, 5'b00100, 4'hF};
    vecs[3] = '{1'b1, 1'b1, 6'd32, 3'd3, 5'b00010, 4'd2};
    vecs[4] = '{1'b1, 1'b1, 6'd34, 3'd4, 5'b00001, 4'd2};
    vecs[5] = '{1'b1, 1'b1, 6'd34, 3'd1, 5'b11000, 4'd2};
    vecs[6] = '{1'b1, 1'b1, 6'd34, 3'd2, 5'b00100, 4'd2};
    vecs[7] = '{1'b1, 1'b1, 6'd34, 3'd3, 5'b00010, 4'd6};
    vecs[8] = '{1'b0, 1'b1, 6'd34, 3'd4, 5'b00001, 4'd6};
    vecs[9] = '{1'b0, 1'b1, 6'd34, 3'd0, 5'b00000, 4'd6};

    RESET = 1'b1;
    rst2  = 1'b1;
    set_in(0, 0, 0, 0, 6'd0);
    bus2.run = 0; bus2.step = 0; bus2.clr_trap = 0; bus2.imem_ready = 0; bus2.funct = 6'd0;
    model_reset();
    #1;
    check_model();
    repeat (3) advance();
    #1;
    check_model();
    RESET = 1'b0;
    rst2  = 1'b0;

    // directed table: two back-to-back instructions in run mode
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].run, 0, 0, vecs[i].ready, vecs[i].funct);
      #1;
      check_model();
      chk("tbl_state", 32'(bus.state), 32'(vecs[i].st));
      chk("tbl_strobes", 32'({bus.pc_write, bus.ir_write, bus.ab_load, bus.alu_out_load, bus.reg_write}),
          32'(vecs[i].strb));
      chk("tbl_alu_ctl", 32'(bus.alu_ctl), 32'(vecs[i].alu));
      advance();
    end
    chk("tbl_count", 32'(bus.retire_count), 32'd2);

    // single step: exactly one instruction, then stays idle
    set_in(0, 1, 0, 1, 6'd37);
    run_cycles(1);
    bus.step = 0;
    run_cycles(6);
    chk("step_state", 32'(bus.state), 32'd0);
    chk("step_alu", 32'(bus.alu_ctl), 32'd1);
    chk("step_count", 32'(bus.retire_count), 32'd3);

    // illegal funct traps after decode; run/step ignored while trapped
    set_in(1, 0, 0, 1, 6'h3F);
    run_cycles(3);
    chk("ill_state", 32'(bus.state), 32'd5);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_count", 32'(bus.retire_count), 32'd3);
    bus.step = 1;
    run_cycles(3);
    chk("ill_hold", 32'(bus.state), 32'd5);
    set_in(0, 0, 1, 1, 6'd32);
    run_cycles(1);
    bus.clr_trap = 0;
    chk("clr_state", 32'(bus.state), 32'd0);
    chk("clr_illegal", 32'(bus.illegal), 32'd0);

    // fetch timeout: eight wait cycles then trap
    set_in(1, 0, 0, 0, 6'd32);
    run_cycles(8);
    chk("to_still_fetch", 32'(bus.state), 32'd1);
    run_cycles(1);
    chk("to_state", 32'(bus.state), 32'd5);
    chk("to_flag", 32'(bus.timeout), 32'd1);
    set_in(0, 0, 1, 0, 6'd32);
    run_cycles(1);
    bus.clr_trap = 0;
    chk("to_clr", 32'(bus.timeout), 32'd0);

    // ready arrives on the third wait cycle; run dropped during EXECUTE
    set_in(1, 0, 0, 0, 6'd36);
    run_cycles(3);
    bus.imem_ready = 1;
    run_cycles(1);
    chk("late_state", 32'(bus.state), 32'd2);
    chk("late_timeout", 32'(bus.timeout), 32'd0);
    run_cycles(1);
    bus.run = 0;
    run_cycles(1);
    chk("drop_wb", 32'(bus.state), 32'd4);
    chk("drop_retire", 32'(bus.retire), 32'd1);
    run_cycles(1);
    chk("drop_idle", 32'(bus.state), 32'd0);
    chk("drop_count", 32'(bus.retire_count), 32'd4);

    // asynchronous reset in EXECUTE clears everything before the next edge
    set_in(1, 0, 0, 1, 6'd42);
    run_cycles(3);
    chk("pre_rst_state", 32'(bus.state), 32'd3);
    RESET = 1'b1;
    model_reset();
    #1;
    check_model();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_alu", 32'(bus.alu_ctl), 32'hF);
    chk("rst_count", 32'(bus.retire_count), 32'd0);
    @(negedge CLK);
    bus.run = 0;
    advance();
    RESET = 1'b0;

    // randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] f;
      case ($urandom_range(7))
        0: f = 6'd32;
        1: f = 6'd34;
        2: f = 6'd36;
        3: f = 6'd37;
        4: f = 6'd39;
        5: f = 6'd42;
        default: f = ($urandom_range(9) == 0) ? 6'($urandom) : 6'd32;
      endcase
      set_in(($urandom_range(3) != 0), ($urandom_range(5) == 0), ($urandom_range(7) == 0),
             ($urandom_range(4) != 0), f);
      run_cycles(1);
    end

    // counter wrap on a 4-bit instance
    bus2.run = 1; bus2.imem_ready = 1; bus2.funct = 6'd32;
    repeat (61) @(posedge CLK);
    @(negedge CLK);
    chk("wrap_pre", 32'(bus2.retire_count), 32'd15);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("wrap_retire", 32'(bus2.retire), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    chk("wrap_zero", 32'(bus2.retire_count), 32'd0);
    chk("wrap_state", 32'(bus2.state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
